seq_stage_controller: RTL and testbench

//  Multi-cycle sequencer for the SEQ Y86-64 datapath: owns the PC register and steps each

---
 rtl/seq_stage_controller_pkg.sv | 50 +++++
 rtl/seq_sat_counter.sv | 20 ++
 rtl/seq_stage_controller.sv | 145 ++++++++++++++
 tb/tb_seq_stage_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_stage_controller_pkg.sv
// Shared definitions for the SEQ stage controller: state encodings, status
// codes, Y86-64 instruction codes and the memory-stage decode helper.
package seq_stage_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPDATE  = 4'd6,
        S_HALT      = 4'd7,
        S_ERROR     = 4'd8,
        S_PAUSE     = 4'd9
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Instructions that touch data memory take the extra MEMORY cycle.
    function automatic logic needs_memory(input logic [3:0] ic);
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    // True for the six states that do datapath work (and count cycles).
    function automatic logic is_stage(input state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXECUTE) ||
               (s == S_MEMORY) || (s == S_WRITEBACK) || (s == S_PCUPDATE);
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module seq_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Clear wins; otherwise count up until every bit is set.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the SEQ Y86-64 datapath. Owns the pc register,
// issues one-hot stage strobes, tracks architectural status and keeps
// saturating cycle / retired-instruction counters.
// Optional build macro SEQ_SINGLE_STEP_EN adds a step input and a PAUSE
// state entered after every PCUPDATE.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | fetch strobe; sample halt / bad-instruction / bad-address
// DECODE    | decode strobe
// EXECUTE   | execute strobe; choose MEMORY or WRITEBACK from icode
// MEMORY    | memory strobe; data address error aborts the instruction
// WRITEBACK | writeback strobe
// PCUPDATE  | load pc from next_pc, retire the instruction
// HALT      | terminal after halt, stat=HLT
// ERROR     | terminal after an address or instruction fault
// PAUSE     | (single-step build only) wait for step before next FETCH
module seq_stage_controller
    import seq_stage_controller_pkg::*;
#(
    parameter int                  PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 step,
`endif
    input  logic [3:0]           icode,
    input  logic                 hlt,
    input  logic                 ins_address,
    input  logic                 adr_address,
    input  logic                 mem_adr_err,
    input  logic [PC_WIDTH-1:0]  next_pc,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 execute_en,
    output logic                 memory_en,
    output logic                 writeback_en,
    output logic                 pcupd_en,
    output logic [2:0]           stat,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] icode_q;
    logic       fetch_fault;
    logic       cycle_inc;
    logic       instr_inc;

    assign fetch_fault = adr_address || ins_address;

    // Next-state decode; HALT and ERROR fall through to the hold default.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (fetch_fault)  state_nxt = S_ERROR;
                else if (hlt)     state_nxt = S_HALT;
                else              state_nxt = S_DECODE;
            end
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE:   state_nxt = needs_memory(icode_q) ? S_MEMORY : S_WRITEBACK;
            S_MEMORY:    state_nxt = mem_adr_err ? S_ERROR : S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_PCUPDATE;
`ifdef SEQ_SINGLE_STEP_EN
            S_PCUPDATE:  state_nxt = S_PAUSE;
            S_PAUSE:     if (step) state_nxt = S_FETCH;
`else
            S_PCUPDATE:  state_nxt = S_FETCH;
`endif
            default:     state_nxt = state;
        endcase
    end

    // State, pc, status and strobes; strobes decode the incoming state so
    // they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            stat         <= STAT_AOK;
            icode_q      <= '0;
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            execute_en   <= 1'b0;
            memory_en    <= 1'b0;
            writeback_en <= 1'b0;
            pcupd_en     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_en     <= (state_nxt == S_FETCH);
            decode_en    <= (state_nxt == S_DECODE);
            execute_en   <= (state_nxt == S_EXECUTE);
            memory_en    <= (state_nxt == S_MEMORY);
            writeback_en <= (state_nxt == S_WRITEBACK);
            pcupd_en     <= (state_nxt == S_PCUPDATE);
            busy         <= is_stage(state_nxt);

            if (state == S_FETCH) begin
                icode_q <= icode;
                if (adr_address)      stat <= STAT_ADR;
                else if (ins_address) stat <= STAT_INS;
                else if (hlt)         stat <= STAT_HLT;
            end

            if ((state == S_MEMORY) && mem_adr_err) begin
                stat <= STAT_ADR;
            end

            if (state == S_PCUPDATE) begin
                pc <= next_pc;
            end
        end
    end

    // A halt retires in FETCH; normal instructions retire in PCUPDATE.
    assign cycle_inc = is_stage(state);
    assign instr_inc = (state == S_PCUPDATE) ||
                       ((state == S_FETCH) && hlt && !fetch_fault);

    seq_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (cycle_inc),
        .count (cycle_cnt)
    );

    seq_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (instr_inc),
        .count (instr_cnt)
    );

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller. Counters are built narrow so
// saturation is reached quickly; RESET_PC is non-zero to make reset visible.
module tb_seq_stage_controller;

    localparam int          PCW = 64;
    localparam int          CW  = 4;
    localparam logic [63:0] RPC = 64'h40;
    localparam int          CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst, start, hlt, ins_address, adr_address, mem_adr_err;
    logic [3:0]     icode;
    logic [PCW-1:0] next_pc, pc;
    logic           fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en;
    logic [2:0]     stat;
    logic           busy;
    logic [CW-1:0]  cycle_cnt, instr_cnt;
    logic [5:0]     strb;
`ifdef SEQ_SINGLE_STEP_EN
    logic           step;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [5:0] exp_q[$];
    logic [5:0] exp_s;
    int         exp_cyc, exp_ins;

    seq_stage_controller #(.PC_WIDTH(PCW), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .icode        (icode),
        .hlt          (hlt),
        .ins_address  (ins_address),
        .adr_address  (adr_address),
        .mem_adr_err  (mem_adr_err),
        .next_pc      (next_pc),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .memory_en    (memory_en),
        .writeback_en (writeback_en),
        .pcupd_en     (pcupd_en),
        .stat         (stat),
        .busy         (busy),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );

    assign strb = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en};

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Expected strobe sequence of one instruction, independent of the DUT.
    function automatic void push_seq(input logic [3:0] ic);
        logic mem;
        mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
              (ic == 4'hA) || (ic == 4'hB);
        exp_q.push_back(6'b100000);
        exp_q.push_back(6'b010000);
        exp_q.push_back(6'b001000);
        if (mem) exp_q.push_back(6'b000100);
        exp_q.push_back(6'b000010);
        exp_q.push_back(6'b000001);
`ifdef SEQ_SINGLE_STEP_EN
        exp_q.push_back(6'b000000);
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; hlt = 1'b0; ins_address = 1'b0;
        adr_address = 1'b0; mem_adr_err = 1'b0; icode = 4'h1; next_pc = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        tick();
        rst = 1'b0;
        exp_cyc = 0;
        exp_ins = 0;
        exp_q.delete();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
        checks++; if (strb !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=000000", strb); end
        checks++; if (stat !== 3'd1) begin failures++; $display("FAIL reset_stat got=%0d exp=1", stat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cycle_cnt !== 4'd0 || instr_cnt !== 4'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt);
        end
    endtask

    // irmovq then mrmovq, then a halt: covers 5- and 6-cycle sequences.
    task automatic test_irmovq_mrmovq_halt();
        do_reset();
        start_pulse();
        icode = 4'h3; next_pc = 64'd10;
        push_seq(icode);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            checks++; if (strb !== exp_s || busy !== (exp_s != 0)) begin
                failures++; $display("FAIL irmovq_strobe got=%b/%b exp=%b", strb, busy, exp_s);
            end
            tick();
            if (exp_s != 0) exp_cyc = sat(exp_cyc);
        end
        exp_ins = sat(exp_ins);
        checks++; if (pc !== 64'd10) begin failures++; $display("FAIL irmovq_pc got=%0d exp=10", pc); end
        checks++; if (instr_cnt !== CW'(exp_ins) || cycle_cnt !== CW'(exp_cyc)) begin
            failures++; $display("FAIL irmovq_counters got=%0d/%0d exp=%0d/%0d", instr_cnt, cycle_cnt, exp_ins, exp_cyc);
        end

        icode = 4'h5; next_pc = 64'd20;
        push_seq(icode);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            checks++; if (strb !== exp_s) begin
                failures++; $display("FAIL mrmovq_strobe got=%b exp=%b", strb, exp_s);
            end
            tick();
            if (exp_s != 0) exp_cyc = sat(exp_cyc);
        end
        exp_ins = sat(exp_ins);
        checks++; if (stat !== 3'd1 || pc !== 64'd20) begin
            failures++; $display("FAIL mrmovq_stat_pc got=%0d/%0d exp=1/20", stat, pc);
        end
        checks++; if (instr_cnt !== CW'(exp_ins) || cycle_cnt !== CW'(exp_cyc)) begin
            failures++; $display("FAIL mrmovq_counters got=%0d/%0d exp=%0d/%0d", instr_cnt, cycle_cnt, exp_ins, exp_cyc);
        end

        hlt = 1'b1; icode = 4'h0;
        checks++; if (strb !== 6'b100000) begin failures++; $display("FAIL halt_fetch got=%b exp=100000", strb); end
        tick();
        hlt = 1'b0;
        exp_cyc = sat(exp_cyc);
        exp_ins = sat(exp_ins);
        checks++; if (stat !== 3'd2 || strb !== 6'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL halt_state got=%0d/%b/%b exp=2/000000/0", stat, strb, busy);
        end
        checks++; if (pc !== 64'd20 || instr_cnt !== CW'(exp_ins) || cycle_cnt !== CW'(exp_cyc)) begin
            failures++; $display("FAIL halt_hold got=%0d/%0d/%0d exp=20/%0d/%0d", pc, instr_cnt, cycle_cnt, exp_ins, exp_cyc);
        end
        start_pulse();
        tick();
        checks++; if (strb !== 6'b0 || stat !== 3'd2 || cycle_cnt !== CW'(exp_cyc)) begin
            failures++; $display("FAIL halt_start_ignored got=%b/%0d/%0d exp=000000/2/%0d", strb, stat, cycle_cnt, exp_cyc);
        end
    endtask

    // Fetch fault priority: adr > ins > hlt.
    task automatic test_fetch_errors();
        logic [2:0] flags [4] = '{3'b110, 3'b010, 3'b011, 3'b101};
        logic [2:0] stat_e[4] = '{3'd3,   3'd4,   3'd4,   3'd3};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            start_pulse();
            {adr_address, ins_address, hlt} = flags[k];
            tick();
            {adr_address, ins_address, hlt} = 3'b000;
            checks++; if (stat !== stat_e[k]) begin
                failures++; $display("FAIL fetch_err_stat case=%0d got=%0d exp=%0d", k, stat, stat_e[k]);
            end
            checks++; if (pc !== RPC || strb !== 6'b0 || instr_cnt !== 4'd0 || cycle_cnt !== 4'd1) begin
                failures++; $display("FAIL fetch_err_hold case=%0d got=%h/%b/%0d/%0d", k, pc, strb, instr_cnt, cycle_cnt);
            end
        end
    endtask

    // pushq hits a data address error in MEMORY.
    task automatic test_mem_err();
        do_reset();
        start_pulse();
        icode = 4'hA; next_pc = 64'd30;
        push_seq(icode);
        for (int k = 0; k < 4; k++) begin
            exp_s = exp_q.pop_front();
            checks++; if (strb !== exp_s) begin
                failures++; $display("FAIL memerr_strobe got=%b exp=%b", strb, exp_s);
            end
            if (exp_s == 6'b000100) mem_adr_err = 1'b1;
            tick();
        end
        mem_adr_err = 1'b0;
        exp_q.delete();
        checks++; if (stat !== 3'd3 || instr_cnt !== 4'd0 || pc !== RPC) begin
            failures++; $display("FAIL memerr_state got=%0d/%0d/%h exp=3/0/%h", stat, instr_cnt, pc, RPC);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (writeback_en !== 1'b0 || strb !== 6'b0) begin
                failures++; $display("FAIL memerr_no_wb got=%b exp=000000", strb);
            end
            tick();
        end
    endtask

    // Reset in the middle of an instruction.
    task automatic test_rst_mid();
        do_reset();
        start_pulse();
        icode = 4'h3; next_pc = 64'd50;
        push_seq(icode);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            tick();
        end
        tick();
        tick();
        checks++; if (strb !== 6'b001000) begin failures++; $display("FAIL rstmid_in_exec got=%b exp=001000", strb); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pc !== RPC || cycle_cnt !== 4'd0 || instr_cnt !== 4'd0) begin
            failures++; $display("FAIL rstmid_clear got=%h/%0d/%0d exp=%h/0/0", pc, cycle_cnt, instr_cnt, RPC);
        end
        checks++; if (strb !== 6'b0 || busy !== 1'b0 || stat !== 3'd1) begin
            failures++; $display("FAIL rstmid_idle got=%b/%b/%0d exp=000000/0/1", strb, busy, stat);
        end
        start_pulse();
        checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL rstmid_restart got=%b exp=1", fetch_en); end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_pause();
        do_reset();
        step = 1'b0;
        start_pulse();
        icode = 4'h3; next_pc = 64'd70;
        for (int k = 0; k < 8; k++) tick();
        checks++; if (strb !== 6'b0 || busy !== 1'b0 || pc !== 64'd70 || cycle_cnt !== 4'd5) begin
            failures++; $display("FAIL pause_hold got=%b/%b/%0d/%0d exp=000000/0/70/5", strb, busy, pc, cycle_cnt);
        end
        step = 1'b1;
        tick();
        checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL pause_step got=%b exp=1", fetch_en); end
    endtask
`endif

    // Random instruction stream; also drives both counters into saturation.
    task automatic test_back_to_back();
        logic [3:0]     ic;
        logic [PCW-1:0] npc;
        logic [PCW-1:0] exp_pc;
        do_reset();
        start_pulse();
        exp_pc = RPC;
        for (int n = 0; n < 18; n++) begin
            ic = 4'($urandom_range(0, 11));
            npc = {$urandom, $urandom};
            icode = ic; next_pc = npc;
            push_seq(ic);
            while (exp_q.size() > 0) begin
                exp_s = exp_q.pop_front();
                checks++; if (strb !== exp_s) begin
                    failures++; $display("FAIL b2b_strobe n=%0d icode=%h got=%b exp=%b", n, ic, strb, exp_s);
                end
                tick();
                if (exp_s != 0) exp_cyc = sat(exp_cyc);
            end
            exp_ins = sat(exp_ins);
            exp_pc = npc;
            checks++; if (pc !== exp_pc || instr_cnt !== CW'(exp_ins) || cycle_cnt !== CW'(exp_cyc)) begin
                failures++; $display("FAIL b2b_state n=%0d got=%h/%0d/%0d exp=%h/%0d/%0d",
                                     n, pc, instr_cnt, cycle_cnt, exp_pc, exp_ins, exp_cyc);
            end
        end
        checks++; if (instr_cnt !== 4'hF || cycle_cnt !== 4'hF) begin
            failures++; $display("FAIL b2b_saturate got=%0d/%0d exp=15/15", instr_cnt, cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_irmovq_mrmovq_halt();
        test_fetch_errors();
        test_mem_err();
        test_rst_mid();
`ifdef SEQ_SINGLE_STEP_EN
        test_pause();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
